kamacore_stage_mem: RTL

KAMACORE_STAGE_MEM -- requirements
Module: kamacore_stage_mem

---
 rtl/kamacore_pkg.sv | 30 +++
 rtl/kamacore_pipeline_stage_if.sv | 13 +
 rtl/kamacore_load_align.sv | 34 +++
 rtl/kamacore_stage_mem.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// rtl/kamacore_pkg.sv - shared widths, opcodes, access sizes and MEM stage FSM states
package kamacore_pkg;

   localparam int CPU_WIDTH      = 32;
   localparam int REG_ADDR_WIDTH = 5;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   // funct3 encodings for loads and stores; bit 2 set means zero-extend
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // access size taken from funct3[1:0]
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_GNT = 2'd1,
      ST_WAIT_RSP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/kamacore_pipeline_stage_if.sv
// rtl/kamacore_pipeline_stage_if.sv - pipeline register bundle passed between stages
interface kamacore_pipeline_stage;
   import kamacore_pkg::*;

   logic                 valid;
   logic [31:0]          instruction;
   logic [CPU_WIDTH-1:0] alu_result;
   logic [CPU_WIDTH-1:0] rs2_data;

   modport master (output valid, instruction, alu_result, rs2_data);
   modport slave  (input  valid, instruction, alu_result, rs2_data);

endinterface

// File: rtl/kamacore_load_align.sv
// rtl/kamacore_load_align.sv - extracts the addressed byte/half of a load word and extends it
module kamacore_load_align
   import kamacore_pkg::*;
(
   input  logic [CPU_WIDTH-1:0] i_rdata,
   input  logic [1:0]           i_addr_lo,
   input  logic [2:0]           i_funct3,
   output logic [CPU_WIDTH-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sign;

   assign w_sign = ~i_funct3[2];

   // pick the lane selected by the low address bits, then extend by access size
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3[1:0])
         SZ_BYTE: o_data = {{24{w_sign & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{w_sign & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/kamacore_stage_mem.sv
// rtl/kamacore_stage_mem.sv - MEM stage: data memory handshake and MEM/WB register; option KAMACORE_MEM_MISALIGN_CHECK_EN
module kamacore_stage_mem
   import kamacore_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   kamacore_pipeline_stage.slave   pipeline_ex_mem,
   kamacore_pipeline_stage.master  pipeline_mem_wb,
   output logic                    mem_stall,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [CPU_WIDTH-1:0]    dmem_addr,
   output logic [3:0]              dmem_be,
   output logic [CPU_WIDTH-1:0]    dmem_wdata,
   input  logic                    dmem_gnt,
   input  logic                    dmem_rvalid,
   input  logic [CPU_WIDTH-1:0]    dmem_rdata,
   output logic                    mem_misaligned
);

   mem_state_e           r_state;
   mem_state_e           w_next_state;
   logic                 r_wb_valid;
   logic [31:0]          r_wb_instr;
   logic [CPU_WIDTH-1:0] r_wb_result;
   logic                 r_misaligned;

   logic                 w_is_load;
   logic                 w_is_store;
   logic                 w_mem_op;
   logic                 w_misaligned;
   logic                 w_active;
   logic                 w_complete;
   logic [1:0]           w_size;
   logic [1:0]           w_addr_lo;
   logic [CPU_WIDTH-1:0] w_load_data;
   logic [CPU_WIDTH-1:0] w_result;
   logic [CPU_WIDTH-1:0] w_addr;
   logic [CPU_WIDTH-1:0] w_wdata_src;

   assign w_addr      = pipeline_ex_mem.alu_result;
   assign w_wdata_src = pipeline_ex_mem.rs2_data;
   assign w_size      = pipeline_ex_mem.instruction[13:12];
   assign w_is_load   = pipeline_ex_mem.valid && (pipeline_ex_mem.instruction[6:0] == OPC_LOAD);
   assign w_is_store  = pipeline_ex_mem.valid && (pipeline_ex_mem.instruction[6:0] == OPC_STORE);
   assign w_mem_op    = w_is_load | w_is_store;

`ifdef KAMACORE_MEM_MISALIGN_CHECK_EN
   assign w_misaligned = w_mem_op &&
                         (((w_size == SZ_HALF) && w_addr[0]) ||
                          ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00)));
`else
   assign w_misaligned = 1'b0;
`endif

   // misaligned ops never reach memory; they retire immediately with a zero result
   assign w_active = w_mem_op & ~w_misaligned;

   // lane offset snapped to the natural alignment of the access size
   assign w_addr_lo = (w_size == SZ_BYTE) ? w_addr[1:0] :
                      (w_size == SZ_HALF) ? {w_addr[1], 1'b0} : 2'b00;

   assign dmem_we    = w_is_store;
   assign dmem_addr  = {w_addr[CPU_WIDTH-1:2], 2'b00};
   assign dmem_be    = (w_size == SZ_BYTE) ? (4'b0001 << w_addr_lo) :
                       (w_size == SZ_HALF) ? (4'b0011 << w_addr_lo) : 4'b1111;
   assign dmem_wdata = (w_size == SZ_BYTE) ? {4{w_wdata_src[7:0]}} :
                       (w_size == SZ_HALF) ? {2{w_wdata_src[15:0]}} : w_wdata_src;

   kamacore_load_align u_load_align (
      .i_rdata   (dmem_rdata),
      .i_addr_lo (w_addr_lo),
      .i_funct3  (pipeline_ex_mem.instruction[14:12]),
      .o_data    (w_load_data)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   // next-state: stores finish on grant, loads wait for the response
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_active)
               w_next_state = dmem_gnt ? (w_is_load ? ST_WAIT_RSP : ST_IDLE) : ST_WAIT_GNT;
         end
         ST_WAIT_GNT: begin
            if (!w_active)     w_next_state = ST_IDLE;
            else if (dmem_gnt) w_next_state = w_is_load ? ST_WAIT_RSP : ST_IDLE;
         end
         ST_WAIT_RSP: begin
            if (dmem_rvalid) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // outputs: request, completion and stall for the current state
   always_comb begin
      dmem_req   = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         ST_IDLE: begin
            dmem_req   = w_active;
            w_complete = pipeline_ex_mem.valid &&
                         (!w_mem_op || w_misaligned || (w_is_store && dmem_gnt));
         end
         ST_WAIT_GNT: begin
            dmem_req   = w_active;
            w_complete = w_active && w_is_store && dmem_gnt;
         end
         ST_WAIT_RSP: begin
            w_complete = dmem_rvalid;
         end
         default: begin
            dmem_req   = 1'b0;
            w_complete = 1'b0;
         end
      endcase
      mem_stall = w_mem_op & ~w_complete;
   end

   // loads only ever complete out of WAIT_RSP, so that is where the aligned data is used
   assign w_result = (r_state == ST_WAIT_RSP) ? w_load_data :
                     (w_misaligned ? '0 : w_addr);

   // MEM/WB register: capture on completion, otherwise emit a bubble
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wb_valid   <= 1'b0;
         r_wb_instr   <= NOP_INSTR;
         r_wb_result  <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_wb_valid   <= w_complete;
         r_misaligned <= w_complete & w_misaligned;
         if (w_complete) begin
            r_wb_instr  <= pipeline_ex_mem.instruction;
            r_wb_result <= w_result;
         end
      end
   end

   assign pipeline_mem_wb.valid       = r_wb_valid;
   assign pipeline_mem_wb.instruction = r_wb_instr;
   assign pipeline_mem_wb.alu_result  = r_wb_result;
   assign pipeline_mem_wb.rs2_data    = '0;
   assign mem_misaligned              = r_misaligned;

endmodule
